// File: rtl/ex_stage.sv
// Execute stage of the 5-stage MIPS pipeline: single-cycle logic and HI/LO moves,
// an iterative radix-2 restoring divider, HI/LO registers and the ex/mem output register.
module ex_stage #(
  parameter int DIV_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  aluop_i,
  input  logic [2:0]  alusel_i,
  input  logic [31:0] reg1_i,
  input  logic [31:0] reg2_i,
  input  logic [4:0]  wd_i,
  input  logic        wreg_i,
  input  logic        flush_i,
  output logic [4:0]  wd_o,
  output logic        wreg_o,
  output logic [31:0] wdata_o,
  output logic        stallreq_o
);

  localparam logic [7:0] EXE_NOP_OP  = 8'h00;
  localparam logic [7:0] EXE_AND_OP  = 8'h24;
  localparam logic [7:0] EXE_OR_OP   = 8'h25;
  localparam logic [7:0] EXE_XOR_OP  = 8'h26;
  localparam logic [7:0] EXE_NOR_OP  = 8'h27;
  localparam logic [7:0] EXE_MFHI_OP = 8'h10;
  localparam logic [7:0] EXE_MTHI_OP = 8'h11;
  localparam logic [7:0] EXE_MFLO_OP = 8'h12;
  localparam logic [7:0] EXE_MTLO_OP = 8'h13;
  localparam logic [7:0] EXE_DIV_OP  = 8'h1A;
  localparam logic [7:0] EXE_DIVU_OP = 8'h1B;

  localparam logic [2:0] EXE_RES_NOP   = 3'b000;
  localparam logic [2:0] EXE_RES_LOGIC = 3'b001;
  localparam logic [2:0] EXE_RES_MOVE  = 3'b011;

  localparam int CNT_W = $clog2(DIV_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } div_state_e;

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [63:0]      rem_q, rem_d;
  logic [31:0]      divisor_q, divisor_d;
  logic             neg_quot_q, neg_quot_d;
  logic             neg_rem_q, neg_rem_d;
  logic             dbz_q, dbz_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;
  logic [4:0]       wd_q, wd_d;
  logic             wreg_q, wreg_d;
  logic [31:0]      wdata_q, wdata_d;

  logic        is_div, is_signed, is_mt;
  logic [31:0] op1_abs, op2_abs;
  logic [32:0] partial, diff;
  logic        ge;
  logic [63:0] rem_step;
  logic [31:0] quot_fix, rem_fix;
  logic [31:0] res;
  logic        res_valid;

  assign is_div    = (aluop_i == EXE_DIV_OP) || (aluop_i == EXE_DIVU_OP);
  assign is_signed = (aluop_i == EXE_DIV_OP);
  assign is_mt     = (aluop_i == EXE_MTHI_OP) || (aluop_i == EXE_MTLO_OP);

  assign op1_abs = (is_signed && reg1_i[31]) ? (32'd0 - reg1_i) : reg1_i;
  assign op2_abs = (is_signed && reg2_i[31]) ? (32'd0 - reg2_i) : reg2_i;

  // The shifted remainder can reach 33 bits, so the compare keeps the carry-out bit.
  assign partial  = rem_q[63:31];
  assign diff     = partial - {1'b0, divisor_q};
  assign ge       = (partial >= {1'b0, divisor_q});
  assign rem_step = ge ? {diff[31:0], rem_q[30:0], 1'b1} : {rem_q[62:0], 1'b0};

  assign quot_fix = (neg_quot_q && !dbz_q) ? (32'd0 - rem_q[31:0])  : rem_q[31:0];
  assign rem_fix  = (neg_rem_q  && !dbz_q) ? (32'd0 - rem_q[63:32]) : rem_q[63:32];

  assign stallreq_o = !rst &&
                      (((state_q == S_IDLE) && is_div && !flush_i) || (state_q == S_RUN));

  // NOTE: every variable is given a default first so no path through the
  // block leaves it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rem_d      = rem_q;
    divisor_d  = divisor_q;
    neg_quot_d = neg_quot_q;
    neg_rem_d  = neg_rem_q;
    dbz_d      = dbz_q;
    hi_d       = hi_q;
    lo_d       = lo_q;

    unique case (state_q)
      S_IDLE: begin
        if (is_div) begin
          neg_quot_d = is_signed && (reg1_i[31] ^ reg2_i[31]);
          neg_rem_d  = is_signed && reg1_i[31];
          if (reg2_i == 32'd0) begin
            // Divide by zero: quotient all-ones, remainder is the raw dividend.
            dbz_d   = 1'b1;
            rem_d   = {reg1_i, 32'hFFFF_FFFF};
            state_d = S_DONE;
          end else begin
            dbz_d     = 1'b0;
            rem_d     = {32'd0, op1_abs};
            divisor_d = op2_abs;
            cnt_d     = '0;
            state_d   = S_RUN;
          end
        end else begin
          if (aluop_i == EXE_MTHI_OP) hi_d = reg1_i;
          if (aluop_i == EXE_MTLO_OP) lo_d = reg1_i;
        end
      end
      S_RUN: begin
        rem_d = rem_step;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(DIV_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        lo_d    = quot_fix;
        hi_d    = rem_fix;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (flush_i) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      hi_d    = hi_q;
      lo_d    = lo_q;
    end
  end

  always_comb begin
    res       = 32'd0;
    res_valid = 1'b0;
    unique case (alusel_i)
      EXE_RES_LOGIC: begin
        res_valid = 1'b1;
        case (aluop_i)
          EXE_AND_OP: res = reg1_i & reg2_i;
          EXE_OR_OP:  res = reg1_i | reg2_i;
          EXE_XOR_OP: res = reg1_i ^ reg2_i;
          EXE_NOR_OP: res = ~(reg1_i | reg2_i);
          default:    res_valid = 1'b0;
        endcase
      end
      EXE_RES_MOVE: begin
        res_valid = 1'b1;
        case (aluop_i)
          EXE_MFHI_OP: res = hi_q;
          EXE_MFLO_OP: res = lo_q;
          EXE_MTHI_OP, EXE_MTLO_OP: res = 32'd0;
          default:     res_valid = 1'b0;
        endcase
      end
      EXE_RES_NOP: res_valid = 1'b0;
      default:     res_valid = 1'b0;
    endcase

    wd_d    = wd_i;
    wreg_d  = wreg_i && res_valid && !is_mt;
    wdata_d = res_valid ? res : 32'd0;

    if (flush_i || stallreq_o || is_div || (aluop_i == EXE_NOP_OP)) begin
      wd_d    = 5'd0;
      wreg_d  = 1'b0;
      wdata_d = 32'd0;
    end
  end

  // NOTE: state uses non-blocking assignments so every flop samples the
  // values from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      rem_q      <= 64'd0;
      divisor_q  <= 32'd0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      dbz_q      <= 1'b0;
      hi_q       <= 32'd0;
      lo_q       <= 32'd0;
      wd_q       <= 5'd0;
      wreg_q     <= 1'b0;
      wdata_q    <= 32'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rem_q      <= rem_d;
      divisor_q  <= divisor_d;
      neg_quot_q <= neg_quot_d;
      neg_rem_q  <= neg_rem_d;
      dbz_q      <= dbz_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      wd_q       <= wd_d;
      wreg_q     <= wreg_d;
      wdata_q    <= wdata_d;
    end
  end

  assign wd_o    = wd_q;
  assign wreg_o  = wreg_q;
  assign wdata_o = wdata_q;

endmodule
